// File: rtl/hub75_row_scheduler.sv
// HUB75 row/bit-plane scheduler: sequences shift, display, blank and latch per
// plane with binary-coded modulation, and swaps front/back buffers at frame end.
module hub75_row_scheduler #(
  parameter int NR_ROWS      = 16,
  parameter int NR_BITPLANES = 4,
  parameter int BASE_TIME    = 64,
  parameter int BLANK_CYCLES = 2,
  localparam int ROW_BITS    = (NR_ROWS > 1) ? $clog2(NR_ROWS) : 1,
  localparam int BP_BITS     = (NR_BITPLANES > 1) ? $clog2(NR_BITPLANES) : 1
) (
  input  logic                clk25,
  input  logic                reset25_,
  input  logic                enable,
  output logic                stream_start,
  output logic [ROW_BITS-1:0] stream_row,
  output logic [BP_BITS-1:0]  stream_bitplane,
  output logic                stream_buf,
  input  logic                stream_done,
  output logic                hub75_lat,
  output logic                hub75_oe_n,
  output logic [ROW_BITS-1:0] hub75_row,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic                frame_start
);

  localparam int MAX_TIME = BASE_TIME << (NR_BITPLANES - 1);
  localparam int CNT_BITS = $clog2(MAX_TIME + 1);
  localparam int BLK_BITS = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SHIFT, ST_WAIT_DISP, ST_BLANK, ST_LATCH
  } state_t;

  state_t              state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [BP_BITS-1:0]  bp_q, bp_d;
  logic                buf_q, buf_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [BLK_BITS-1:0] blank_q, blank_d;
  logic                start_q, start_d;
  logic                frame_q, frame_d;
  logic                ack_q, ack_d;
  logic                lat_q, lat_d;
  logic                oe_n_q, oe_n_d;
  logic [ROW_BITS-1:0] hrow_q, hrow_d;
  logic                last_bp, last_row, frame_end;

  always_ff @(posedge clk25 or negedge reset25_) begin
    if (!reset25_) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      bp_q    <= '0;
      buf_q   <= 1'b0;
      cnt_q   <= '0;
      blank_q <= '0;
      start_q <= 1'b0;
      frame_q <= 1'b0;
      ack_q   <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      hrow_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      bp_q    <= bp_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      start_q <= start_d;
      frame_q <= frame_d;
      ack_q   <= ack_d;
      lat_q   <= lat_d;
      oe_n_q  <= oe_n_d;
      hrow_q  <= hrow_d;
    end
  end

  // A done pulse coinciding with the start pulse belongs to a previous shift.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enable) state_d = ST_SHIFT;
      ST_SHIFT:     if (stream_done && !start_q) state_d = ST_WAIT_DISP;
      ST_WAIT_DISP: if (cnt_q == '0) state_d = ST_BLANK;
      ST_BLANK:     if (blank_q == '0) state_d = ST_LATCH;
      ST_LATCH:     state_d = enable ? ST_SHIFT : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_bp   = (bp_q == BP_BITS'(NR_BITPLANES - 1));
    last_row  = (row_q == ROW_BITS'(NR_ROWS - 1));
    frame_end = (state_q == ST_LATCH) && last_bp && last_row;

    row_d  = row_q;
    bp_d   = bp_q;
    hrow_d = hrow_q;
    if (state_q == ST_IDLE && enable) begin
      row_d = '0;
      bp_d  = '0;
    end else if (state_q == ST_LATCH) begin
      hrow_d = row_q;
      if (last_bp) begin
        bp_d  = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        bp_d = bp_q + 1'b1;
      end
    end

    buf_d = buf_q ^ (frame_end & swap_req);
    ack_d = frame_end & swap_req;

    start_d = (state_d == ST_SHIFT) && (state_q != ST_SHIFT);
    frame_d = start_d && (row_d == '0) && (bp_d == '0);
    lat_d   = (state_d == ST_LATCH);

    blank_d = BLK_BITS'(BLANK_CYCLES - 1);
    if (state_q == ST_BLANK && blank_q != '0)
      blank_d = blank_q - 1'b1;

    // Display counter is free-running so a new shift overlaps the current plane.
    cnt_d = cnt_q;
    if (state_q == ST_LATCH)
      cnt_d = CNT_BITS'(BASE_TIME) << bp_q;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
    oe_n_d = (cnt_d == '0);
  end

  assign stream_start    = start_q;
  assign frame_start     = frame_q;
  assign stream_row      = row_q;
  assign stream_bitplane = bp_q;
  assign stream_buf      = buf_q;
  assign swap_ack        = ack_q;
  assign hub75_lat       = lat_q;
  assign hub75_oe_n      = oe_n_q;
  assign hub75_row       = hrow_q;

endmodule

// File: tb/tb_hub75_row_scheduler.sv
// Scoreboard bench for hub75_row_scheduler: expected shifts, latches and swaps
// are queued up front and independent monitors pop and compare them.
module tb_hub75_row_scheduler;

  logic       clk25 = 1'b0;
  logic       reset25_;
  logic       enable;
  logic       stream_start;
  logic [1:0] stream_row;
  logic [0:0] stream_bitplane;
  logic       stream_buf;
  logic       stream_done;
  logic       hub75_lat;
  logic       hub75_oe_n;
  logic [1:0] hub75_row;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_start;

  hub75_row_scheduler #(
    .NR_ROWS(4), .NR_BITPLANES(2), .BASE_TIME(8), .BLANK_CYCLES(2)
  ) dut (
    .clk25(clk25), .reset25_(reset25_), .enable(enable),
    .stream_start(stream_start), .stream_row(stream_row),
    .stream_bitplane(stream_bitplane), .stream_buf(stream_buf),
    .stream_done(stream_done), .hub75_lat(hub75_lat), .hub75_oe_n(hub75_oe_n),
    .hub75_row(hub75_row), .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_start(frame_start)
  );

  always #5 clk25 = ~clk25;

  typedef struct {
    int row;
    int bp;
    int sbuf;
    int fs;
  } start_t;

  start_t exp_start[$];
  int     exp_lat_row[$];
  int     exp_lat_len[$];
  int     exp_swap[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int lat_cnt = 0;
  int fs_cnt = 0;
  int swap_cnt = 0;
  int oe_low = 0;
  int exp_oe_low = 0;
  int first_start_cyc = 0;
  int done_dly = 5;
  int done_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_plane(input int row, input int bp, input int sbuf, input int len);
    start_t e;
    e.row = row; e.bp = bp; e.sbuf = sbuf; e.fs = (row == 0 && bp == 0) ? 1 : 0;
    exp_start.push_back(e);
    if (len > 0) begin
      exp_lat_row.push_back(row);
      exp_lat_len.push_back(len);
      exp_oe_low += len;
    end
  endtask

  task automatic wait_starts(input int n);
    int budget = 3000;
    while (start_cnt < n && budget > 0) begin
      @(posedge clk25);
      budget--;
    end
    if (start_cnt < n) check("timeout_starts", start_cnt, n);
    @(negedge clk25);
  endtask

  task automatic wait_lats(input int n);
    int budget = 3000;
    while (lat_cnt < n && budget > 0) begin
      @(posedge clk25);
      budget--;
    end
    if (lat_cnt < n) check("timeout_lats", lat_cnt, n);
    @(negedge clk25);
  endtask

  always @(posedge clk25) cyc <= cyc + 1;

  always @(negedge clk25)
    if (reset25_ && !hub75_oe_n) oe_low <= oe_low + 1;

  // Streamer model: one-cycle done pulse done_dly cycles after each start.
  initial begin
    int busy = 0;
    int dcnt = 0;
    stream_done = 1'b0;
    forever begin
      @(negedge clk25);
      if (!reset25_) begin
        busy = 0;
        dcnt = 0;
        stream_done = 1'b0;
      end else begin
        stream_done = 1'b0;
        if (busy != 0) begin
          dcnt--;
          if (dcnt == 0) begin
            stream_done = 1'b1;
            busy = 0;
            done_seen = 1;
          end
        end
        if (stream_start) begin
          busy = 1;
          dcnt = done_dly;
          done_seen = 0;
        end
      end
    end
  end

  // Start monitor.
  initial begin
    start_t e;
    forever begin
      @(negedge clk25);
      if (reset25_ && stream_start) begin
        start_cnt++;
        if (start_cnt == 1) first_start_cyc = cyc;
        if (frame_start) fs_cnt++;
        $display("start #%0d row=%0d bp=%0d buf=%0d fs=%0d", start_cnt,
                 stream_row, stream_bitplane, stream_buf, frame_start);
        if (exp_start.size() == 0) begin
          check("unexpected_start", start_cnt, 0);
        end else begin
          e = exp_start.pop_front();
          check("start_row", int'(stream_row), e.row);
          check("start_bp", int'(stream_bitplane), e.bp);
          check("start_buf", int'(stream_buf), e.sbuf);
          check("start_frame_start", int'(frame_start), e.fs);
        end
      end else if (reset25_ && frame_start) begin
        check("frame_start_without_start", 1, 0);
      end
    end
  end

  // Latch monitor: row shown after the latch and length of the oe_n low window.
  initial begin
    int erow, elen, len;
    forever begin
      @(negedge clk25);
      if (reset25_ && hub75_lat) begin
        lat_cnt++;
        check("lat_oe_overlap", int'(hub75_oe_n), 1);
        check("lat_after_done", done_seen, 1);
        if (lat_cnt == 1) check("first_lat_delay", cyc - first_start_cyc, 9);
        if (exp_lat_row.size() == 0) begin
          check("unexpected_lat", lat_cnt, 0);
          erow = -1;
          elen = -1;
        end else begin
          erow = exp_lat_row.pop_front();
          elen = exp_lat_len.pop_front();
        end
        @(negedge clk25);
        check("lat_width", int'(hub75_lat), 0);
        check("disp_row", int'(hub75_row), erow);
        len = 0;
        while (!hub75_oe_n && len < 100) begin
          len++;
          @(negedge clk25);
        end
        $display("latch #%0d row=%0d display=%0d", lat_cnt, hub75_row, len);
        check("disp_len", len, elen);
      end
    end
  end

  // Swap monitor.
  initial begin
    forever begin
      @(negedge clk25);
      if (reset25_ && swap_ack) begin
        swap_cnt++;
        $display("swap #%0d buf=%0d", swap_cnt, stream_buf);
        if (exp_swap.size() == 0) check("unexpected_swap", swap_cnt, 0);
        else check("swap_buf", int'(stream_buf), exp_swap.pop_front());
      end
    end
  end

  initial begin
    // Frames 0..3 complete; frame 0 ends with no swap request, 1..3 swap.
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 4; r++)
        for (int b = 0; b < 2; b++)
          push_plane(r, b, (f == 2) ? 1 : 0, (b == 1) ? 16 : 8);
    // Frame 4 stops after row 2 plane 0 when enable drops.
    for (int i = 0; i < 5; i++)
      push_plane(i / 2, i % 2, 1, (i % 2 == 1) ? 16 : 8);
    // Restart from idle, then reset three cycles into the first display.
    push_plane(0, 0, 1, 3);
    push_plane(0, 1, 1, 0);
    // After reset: buffer back to 0, one plane then stop.
    push_plane(0, 0, 0, 8);
    exp_swap.push_back(1);
    exp_swap.push_back(0);
    exp_swap.push_back(1);

    enable = 1'b0;
    swap_req = 1'b0;
    reset25_ = 1'b1;
    #1 reset25_ = 1'b0;
    #1;
    check("rst_oe_n", int'(hub75_oe_n), 1);
    check("rst_lat", int'(hub75_lat), 0);
    check("rst_start", int'(stream_start), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_swap_ack", int'(swap_ack), 0);
    check("rst_buf", int'(stream_buf), 0);
    check("rst_hub75_row", int'(hub75_row), 0);
    check("rst_stream_row", int'(stream_row), 0);
    check("rst_bitplane", int'(stream_bitplane), 0);
    repeat (3) @(negedge clk25);
    reset25_ = 1'b1;
    repeat (4) @(negedge clk25);
    check("idle_no_start", start_cnt, 0);

    enable = 1'b1;
    wait_starts(12);
    swap_req = 1'b1;
    wait_starts(16);
    done_dly = 30;
    wait_starts(24);
    done_dly = 5;
    wait_starts(34);
    swap_req = 1'b0;
    wait_starts(37);
    enable = 1'b0;
    wait_lats(37);
    repeat (40) @(negedge clk25);
    check("idle_oe_n", int'(hub75_oe_n), 1);
    check("idle_start_count", start_cnt, 37);

    enable = 1'b1;
    wait_lats(38);
    repeat (2) @(negedge clk25);
    #1 reset25_ = 1'b0;
    #1;
    check("async_rst_oe_n", int'(hub75_oe_n), 1);
    check("async_rst_lat", int'(hub75_lat), 0);
    check("async_rst_buf", int'(stream_buf), 0);
    check("async_rst_bitplane", int'(stream_bitplane), 0);
    check("async_rst_start", int'(stream_start), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk25);
    reset25_ = 1'b1;
    @(negedge clk25);
    enable = 1'b1;
    wait_starts(40);
    enable = 1'b0;
    wait_lats(39);
    repeat (40) @(negedge clk25);

    check("final_start_count", start_cnt, 40);
    check("final_lat_count", lat_cnt, 39);
    check("final_frame_starts", fs_cnt, 7);
    check("final_swaps", swap_cnt, 3);
    check("final_oe_low_total", oe_low, exp_oe_low);
    check("final_pending_starts", exp_start.size(), 0);
    check("final_pending_lats", exp_lat_row.size(), 0);
    check("final_pending_swaps", exp_swap.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
